peripheral_arbiter_master_ahb3: RTL
===================================

// Module: peripheral_arbiter_master_ahb3
// PURPOSE
//  Shares one AHB-Lite slave-side bus between N AHB-Lite masters (BFMs, DMA channels).
//  Round-robin arbitration; the grant moves only at an accepted IDLE, so bursts are never split.
//  Muxes the address/control phase by address owner and HWDATA by a registered data-phase owner.
//  Gates per-master HREADY to stall masters that do not hold the grant.
// PARAMETERS
//  MASTERS     2   number of requesting masters (>=2)
//  HADDR_SIZE  16  address width
//  HDATA_SIZE  32  data width
// PORTS
//  HRESETn      in   1               async reset, active low
//  HCLK         in   1               clock
//  M_HSEL       in   MASTERS         per-master select
//  M_HADDR      in   MASTERS*HADDR   flattened, master i at [i*HADDR_SIZE+:HADDR_SIZE]
//  M_HWDATA     in   MASTERS*HDATA   flattened write data
//  M_HWRITE     in   MASTERS         write strobe
//  M_HSIZE      in   MASTERS*3       size
//  M_HBURST     in   MASTERS*3       burst type
//  M_HPROT      in   MASTERS*4       protection
//  M_HTRANS     in   MASTERS*2       transfer type
//  M_HMASTLOCK  in   MASTERS         locked sequence
//  M_HRDATA     out  HDATA_SIZE      broadcast of S_HRDATA
//  M_HREADY     out  MASTERS         per-master ready
//  M_HRESP      out  MASTERS         per-master response
//  S_HSEL..S_HMASTLOCK out           muxed slave-side address/control + S_HWDATA
//  S_HRDATA     in   HDATA_SIZE      slave read data
//  S_HREADY     in   1               slave ready
//  S_HRESP      in   1               slave response
//  GRANT        out  MASTERS         one-hot address owner
// BEHAVIOUR
//  State: addr_own (index), data_own (index), data_vld (bit), rr_ptr (last granted index).
//  Reset: addr_own=0, data_own=0, data_vld=0, rr_ptr=0; GRANT=...0001.
//  Reset: S_* follows master 0; M_HREADY all 1; M_HRESP all 0.
//  req[i] = M_HSEL[i] & (M_HTRANS[i]==NONSEQ).
//  Release condition, evaluated on the edge:
//   S_HREADY=1 and owner presents IDLE or HSEL=0, with owner HMASTLOCK=0.
//  On release with some req[j], j!=addr_own:
//   addr_own <= first requester after rr_ptr (wrapping MASTERS-1 -> 0).
//   rr_ptr <= that winner.
//  With no other requester: grant stays parked; a parked owner issues with 0 cycles added latency.
//  Address phase (comb): S_HSEL/HADDR/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HMASTLOCK = addr_own's inputs.
//  Data phase, on edge with S_HREADY=1:
//   data_own <= addr_own.
//   data_vld <= S_HSEL & S_HTRANS[1] (NONSEQ/SEQ).
//  S_HWDATA = M_HWDATA[data_own], even when data_vld=0.
//  M_HREADY[i]:
//   i==addr_own or (data_vld & i==data_own): S_HREADY.
//   otherwise: 0 if req[i], else 1 (non-owner IDLE/BUSY completes zero-wait).
//  M_HRESP[i] = S_HRESP when data_vld & i==data_own; else 0 (OKAY).
//  Grant change latency: new owner's NONSEQ drives S bus the cycle after the release edge.
//  A stalled master holds its address per AHB rules; the arbiter adds no storage.
//  HRESP ERROR is forwarded unchanged; arbitration is unaffected by it.
//  HMASTLOCK=1 on the owner blocks release even at IDLE.
//  HRESETn low mid-burst: all state returns to reset values asynchronously; the in-flight transfer is dropped.
// TESTING
//  Parked m0, single write m0 A=0x10 D=0xCAFE -> S bus NONSEQ A=0x10 same cycle; S_HWDATA=0xCAFE next beat.
//  m0 idle, m1 NONSEQ read 0x20 -> M_HREADY[1]=0 one cycle; GRANT=2'b10; S_HADDR=0x20 next cycle.
//  m1 read data: S_HRDATA=0x1234 -> m1 receives 0x1234.
//  m0 INCR4 at 0x40 + m1 request -> 4 beats 0x40..0x4C unbroken; then IDLE, then m1 granted.
//  m0,m1 request simultaneously, repeated singles -> grants alternate m0,m1,m0,m1 (round robin).
//  m0 HMASTLOCK=1 with IDLE gaps, m1 requesting -> GRANT stays m0 until HMASTLOCK=0 and IDLE.
//  Slave inserts 2 wait states on m1 write -> M_HREADY[1] low 2 cycles; S_HWDATA stable.
//  Same case, stalled m0 -> M_HREADY[0] low.
//  Slave ERROR on m1 -> M_HRESP[1]=1, M_HRESP[0]=0.
//  HRESETn pulse mid-INCR4 -> GRANT=01, data_vld=0, S_HTRANS follows m0.

Source files
------------

// File: rtl/peripheral_arbiter_master_ahb3_if.sv
// Bus bundle for the AHB-Lite master arbiter: N flattened master ports on one side,
// one slave-side port on the other, plus the one-hot grant vector.
interface peripheral_arbiter_master_ahb3_if #(
   parameter int MASTERS    = 2,
   parameter int HADDR_SIZE = 16,
   parameter int HDATA_SIZE = 32
);
   logic [MASTERS-1:0]            M_HSEL;
   logic [MASTERS*HADDR_SIZE-1:0] M_HADDR;
   logic [MASTERS*HDATA_SIZE-1:0] M_HWDATA;
   logic [MASTERS-1:0]            M_HWRITE;
   logic [MASTERS*3-1:0]          M_HSIZE;
   logic [MASTERS*3-1:0]          M_HBURST;
   logic [MASTERS*4-1:0]          M_HPROT;
   logic [MASTERS*2-1:0]          M_HTRANS;
   logic [MASTERS-1:0]            M_HMASTLOCK;
   logic [HDATA_SIZE-1:0]         M_HRDATA;
   logic [MASTERS-1:0]            M_HREADY;
   logic [MASTERS-1:0]            M_HRESP;

   logic                          S_HSEL;
   logic [HADDR_SIZE-1:0]         S_HADDR;
   logic [HDATA_SIZE-1:0]         S_HWDATA;
   logic                          S_HWRITE;
   logic [2:0]                    S_HSIZE;
   logic [2:0]                    S_HBURST;
   logic [3:0]                    S_HPROT;
   logic [1:0]                    S_HTRANS;
   logic                          S_HMASTLOCK;
   logic [HDATA_SIZE-1:0]         S_HRDATA;
   logic                          S_HREADY;
   logic                          S_HRESP;

   logic [MASTERS-1:0]            GRANT;

   // Arbiter view: consumes the master ports, drives the shared slave port.
   modport master (
      input  M_HSEL, M_HADDR, M_HWDATA, M_HWRITE, M_HSIZE, M_HBURST, M_HPROT,
             M_HTRANS, M_HMASTLOCK,
      output M_HRDATA, M_HREADY, M_HRESP,
      output S_HSEL, S_HADDR, S_HWDATA, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT,
             S_HTRANS, S_HMASTLOCK,
      input  S_HRDATA, S_HREADY, S_HRESP,
      output GRANT
   );

   // Environment view: masters and the slave attached around the arbiter.
   modport slave (
      output M_HSEL, M_HADDR, M_HWDATA, M_HWRITE, M_HSIZE, M_HBURST, M_HPROT,
             M_HTRANS, M_HMASTLOCK,
      input  M_HRDATA, M_HREADY, M_HRESP,
      input  S_HSEL, S_HADDR, S_HWDATA, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT,
             S_HTRANS, S_HMASTLOCK,
      output S_HRDATA, S_HREADY, S_HRESP,
      input  GRANT
   );
endinterface

// File: rtl/peripheral_arbiter_master_ahb3.sv
// Round-robin AHB-Lite arbiter sharing one slave port between MASTERS masters.
// The grant moves only at an accepted IDLE (or deselect) of an unlocked owner, so bursts stay whole.
module peripheral_arbiter_master_ahb3 #(
   parameter int MASTERS    = 2,
   parameter int HADDR_SIZE = 16,
   parameter int HDATA_SIZE = 32
) (
   input logic HRESETn,
   input logic HCLK,
   peripheral_arbiter_master_ahb3_if.master bus
);
   localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef logic [IW-1:0] idx_t;

   idx_t               addr_own_q, addr_own_d;
   idx_t               data_own_q, data_own_d;
   idx_t               rr_ptr_q,   rr_ptr_d;
   logic               data_vld_q, data_vld_d;
   logic [MASTERS-1:0] req_s;
   logic               release_s;
   logic               found_s;
   int                 cand_i;
   idx_t               cand_s;

   // Only a fresh NONSEQ counts as a request for the bus.
   always_comb begin
      req_s = '0;
      for (int i = 0; i < MASTERS; i++) begin
         req_s[i] = bus.M_HSEL[i] & (bus.M_HTRANS[i*2 +: 2] == HTRANS_NONSEQ);
      end
   end

   // Owner may hand over only when its IDLE/deselect is accepted and it is not locked.
   always_comb begin
      release_s = bus.S_HREADY
                & ((bus.M_HTRANS[addr_own_q*2 +: 2] == HTRANS_IDLE) | ~bus.M_HSEL[addr_own_q])
                & ~bus.M_HMASTLOCK[addr_own_q];
   end

   // Next-state: data-phase tracking and round-robin search starting after rr_ptr.
   always_comb begin
      addr_own_d = addr_own_q;
      rr_ptr_d   = rr_ptr_q;
      data_own_d = data_own_q;
      data_vld_d = data_vld_q;
      found_s    = 1'b0;
      cand_i     = 0;
      cand_s     = '0;
      if (bus.S_HREADY) begin
         data_own_d = addr_own_q;
         data_vld_d = bus.S_HSEL & bus.S_HTRANS[1];
      end else begin
         data_own_d = data_own_q;
         data_vld_d = data_vld_q;
      end
      if (release_s) begin
         for (int k = 1; k < MASTERS; k++) begin
            cand_i = int'(rr_ptr_q) + k;
            if (cand_i >= MASTERS) begin
               cand_i = cand_i - MASTERS;
            end else begin
               cand_i = cand_i;
            end
            cand_s = idx_t'(cand_i);
            if (!found_s && (cand_s != addr_own_q) && req_s[cand_s]) begin
               found_s    = 1'b1;
               addr_own_d = cand_s;
               rr_ptr_d   = cand_s;
            end else begin
               found_s    = found_s;
            end
         end
      end else begin
         addr_own_d = addr_own_q;
         rr_ptr_d   = rr_ptr_q;
      end
   end

   // Arbitration state; reset drops any in-flight transfer immediately.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_own_q <= '0;
         data_own_q <= '0;
         rr_ptr_q   <= '0;
         data_vld_q <= 1'b0;
      end else begin
         addr_own_q <= addr_own_d;
         data_own_q <= data_own_d;
         rr_ptr_q   <= rr_ptr_d;
         data_vld_q <= data_vld_d;
      end
   end

   // Address/control follows the address owner; write data follows the data-phase owner.
   always_comb begin
      bus.S_HSEL      = bus.M_HSEL[addr_own_q];
      bus.S_HADDR     = bus.M_HADDR[addr_own_q*HADDR_SIZE +: HADDR_SIZE];
      bus.S_HWRITE    = bus.M_HWRITE[addr_own_q];
      bus.S_HSIZE     = bus.M_HSIZE[addr_own_q*3 +: 3];
      bus.S_HBURST    = bus.M_HBURST[addr_own_q*3 +: 3];
      bus.S_HPROT     = bus.M_HPROT[addr_own_q*4 +: 4];
      bus.S_HTRANS    = bus.M_HTRANS[addr_own_q*2 +: 2];
      bus.S_HMASTLOCK = bus.M_HMASTLOCK[addr_own_q];
      bus.S_HWDATA    = bus.M_HWDATA[data_own_q*HDATA_SIZE +: HDATA_SIZE];
      bus.M_HRDATA    = bus.S_HRDATA;
   end

   // Non-owners that request are stalled; idle non-owners see a zero-wait OKAY.
   always_comb begin
      bus.M_HREADY = '0;
      bus.M_HRESP  = '0;
      bus.GRANT    = '0;
      for (int i = 0; i < MASTERS; i++) begin
         if ((idx_t'(i) == addr_own_q) || (data_vld_q && (idx_t'(i) == data_own_q))) begin
            bus.M_HREADY[i] = bus.S_HREADY;
         end else begin
            bus.M_HREADY[i] = ~req_s[i];
         end
         if (data_vld_q && (idx_t'(i) == data_own_q)) begin
            bus.M_HRESP[i] = bus.S_HRESP;
         end else begin
            bus.M_HRESP[i] = 1'b0;
         end
         bus.GRANT[i] = (idx_t'(i) == addr_own_q);
      end
   end
endmodule
